// File: rtl/pixel_clip_writer.sv
// rtl/pixel_clip_writer.sv - clips (x,y) to the framebuffer, buffers linear addresses, issues writes
// Optional consecutive-duplicate removal: define PIXEL_DEDUP_EN.
module pixel_clip_writer #(
    parameter int FB_W       = 64,
    parameter int FB_H       = 64,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              _clock,
    input  logic              _reset,
    input  logic              _in_valid,
    input  logic [31:0]       _in0,
    input  logic [31:0]       _in1,
    input  logic              _in_done,
    output logic              _in_ready,
    output logic              _wr_valid,
    output logic [ADDR_W-1:0] _wr_addr,
    input  logic              _wr_ready,
    output logic              _done,
    output logic [15:0]       _clip_cnt,
    output logic [15:0]       _dup_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    if ((64'd1 << ADDR_W) < (64'(FB_W) * 64'(FB_H))) begin : g_bad_addr_w
        $error("pixel_clip_writer: ADDR_W too small for FB_W*FB_H");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pixel_clip_writer: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              accept;
    logic              in_win;
    logic [ADDR_W-1:0] in_addr;

    logic              s1_valid;
    logic              s1_win;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_dup;
    logic              push;
    logic              pop;

    logic [ADDR_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  occupancy;
    logic              fifo_empty;

    // Window test uses full 32-bit signed compares; the address only needs the
    // low ADDR_W bits of y*FB_W + x, which depend only on the low operand bits.
    always_comb begin
        in_win  = ($signed(_in0) >= 0) && ($signed(_in0) < FB_W) &&
                  ($signed(_in1) >= 0) && ($signed(_in1) < FB_H);
        in_addr = (_in1[ADDR_W-1:0] * ADDR_W'(FB_W)) + _in0[ADDR_W-1:0];
    end

    assign fifo_empty = (count == '0);
    assign occupancy  = OCC_W'(count) + OCC_W'(s1_valid);
    assign _in_ready  = !_reset && (state == ST_RUN) && (occupancy < OCC_W'(FIFO_DEPTH));
    assign _wr_valid  = !_reset && !fifo_empty;
    assign _wr_addr   = _wr_valid ? mem[rd_ptr] : '0;
    assign _done      = !_reset && (state == ST_DONE);

    assign accept = _in_valid && _in_ready;
    assign pop    = _wr_valid && _wr_ready;
    assign push   = s1_valid && s1_win && !s1_dup;

    always_ff @(posedge _clock) begin
        if (_reset) begin
            s1_valid <= 1'b0;
            s1_win   <= 1'b0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_win  <= in_win;
                s1_addr <= in_addr;
            end
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            _clip_cnt <= 16'd0;
        end else if (s1_valid && !s1_win && (_clip_cnt != 16'hFFFF)) begin
            _clip_cnt <= _clip_cnt + 16'd1;
        end
    end

`ifdef PIXEL_DEDUP_EN
    logic              last_valid;
    logic [ADDR_W-1:0] last_addr;

    assign s1_dup = last_valid && (last_addr == s1_addr);

    always_ff @(posedge _clock) begin
        if (_reset) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_addr  <= s1_addr;
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            _dup_cnt <= 16'd0;
        end else if (s1_valid && s1_win && s1_dup && (_dup_cnt != 16'hFFFF)) begin
            _dup_cnt <= _dup_cnt + 16'd1;
        end
    end
`else
    assign s1_dup   = 1'b0;
    assign _dup_cnt = 16'd0;
`endif

    // Flow control reserves a slot for S1, so a push never meets a full FIFO.
    always_ff @(posedge _clock) begin
        if (push) begin
            mem[wr_ptr] <= s1_addr;
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (_in_done) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid && fifo_empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_pixel_clip_writer.sv
// tb/tb_pixel_clip_writer.sv - randomized self-checking bench for pixel_clip_writer
module tb_pixel_clip_writer;

    localparam int FB_W   = 64;
    localparam int FB_H   = 64;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;

    logic              _clock = 1'b0;
    logic              _reset = 1'b1;
    logic              _in_valid = 1'b0;
    logic [31:0]       _in0 = '0;
    logic [31:0]       _in1 = '0;
    logic              _in_done = 1'b0;
    logic              _in_ready;
    logic              _wr_valid;
    logic [ADDR_W-1:0] _wr_addr;
    logic              _wr_ready = 1'b0;
    logic              _done;
    logic [15:0]       _clip_cnt;
    logic [15:0]       _dup_cnt;

    pixel_clip_writer #(
        .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        ._clock(_clock), ._reset(_reset), ._in_valid(_in_valid), ._in0(_in0), ._in1(_in1),
        ._in_done(_in_done), ._in_ready(_in_ready), ._wr_valid(_wr_valid), ._wr_addr(_wr_addr),
        ._wr_ready(_wr_ready), ._done(_done), ._clip_cnt(_clip_cnt), ._dup_cnt(_dup_cnt)
    );

    always #5 _clock = ~_clock;

    typedef struct { int x; int y; int cyc; } acc_t;
    typedef struct { int addr; int cyc; } wr_t;

    acc_t acc_q[$];
    wr_t  wr_log[$];
    int   exp_q[$];
    int   exp_clip, exp_dup;
    int   checks = 0, failures = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   stab_err = 0;
    logic stalled = 1'b0;
    logic [ADDR_W-1:0] stall_addr = '0;
    acc_t mon_a;
    wr_t  mon_w;

    always @(posedge _clock) cyc <= cyc + 1;

    always @(posedge _clock) begin
        #1;
        if (ready_mode == 2) _wr_ready = 1'($urandom_range(0, 1));
        else                 _wr_ready = (ready_mode == 1);
    end

    // Handshakes resolve at the next rising edge; inputs are stable from here to there.
    always @(negedge _clock) begin
        if (!_reset) begin
            if (_in_valid && _in_ready) begin
                mon_a.x = int'($signed(_in0)); mon_a.y = int'($signed(_in1)); mon_a.cyc = cyc;
                acc_q.push_back(mon_a);
            end
            if (_wr_valid && _wr_ready) begin
                mon_w.addr = int'(_wr_addr); mon_w.cyc = cyc;
                wr_log.push_back(mon_w);
            end
            if (stalled && _wr_valid && (_wr_addr !== stall_addr)) stab_err++;
            stalled    = _wr_valid && !_wr_ready;
            stall_addr = _wr_addr;
        end else begin
            stalled = 1'b0;
        end
    end

    function automatic void run_model();
        int   last;
        bit   last_v;
        int   a;
        exp_q.delete();
        exp_clip = 0; exp_dup = 0; last = 0; last_v = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i].x < 0 || acc_q[i].x >= FB_W || acc_q[i].y < 0 || acc_q[i].y >= FB_H) begin
                exp_clip++;
            end else begin
                a = acc_q[i].y * FB_W + acc_q[i].x;
`ifdef PIXEL_DEDUP_EN
                if (last_v && a == last) begin
                    exp_dup++;
                    continue;
                end
`endif
                exp_q.push_back(a);
                last = a; last_v = 1;
            end
        end
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin @(posedge _clock); #1; end
    endtask

    task automatic apply_reset();
        _reset = 1'b1; _in_valid = 1'b0; _in_done = 1'b0;
        step(2);
        acc_q.delete(); wr_log.delete(); stab_err = 0;
        _reset = 1'b0;
    endtask

    task automatic send(int x, int y);
        _in0 = 32'(x); _in1 = 32'(y); _in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge _clock);
            if (_in_ready) begin
                step(1);
                _in_valid = 1'b0;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL send_timeout: in_ready never rose for (%0d,%0d)", x, y);
        _in_valid = 1'b0;
    endtask

    task automatic finish_stream(string name);
        _in_done = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge _clock);
            if (_done) break;
        end
        checks++;
        if (_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: got %b expected 1", name, _done);
        end
        step(1);
    endtask

    task automatic test_reset();
        _reset = 1'b1;
        step(1);
        @(negedge _clock);
        checks++;
        if ({_in_ready, _wr_valid, _done} !== 3'b000 || _wr_addr !== '0 ||
            _clip_cnt !== 16'd0 || _dup_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b wv=%b addr=%0d done=%b clip=%0d dup=%0d expected all 0",
                     _in_ready, _wr_valid, _wr_addr, _done, _clip_cnt, _dup_cnt);
        end
        step(1);
        _reset = 1'b0;
        @(negedge _clock);
        checks++;
        if (_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after: got %b expected 1", _in_ready);
        end
    endtask

    task automatic test_single_point();
        ready_mode = 1;
        apply_reset();
        send(3, 2);
        step(4);
        run_model();
        checks++;
        if (wr_log.size() !== 1 || exp_q.size() !== 1) begin
            failures++;
            $display("FAIL single_count: got %0d expected %0d", wr_log.size(), exp_q.size());
        end else begin
            checks++;
            if (wr_log[0].addr !== exp_q[0]) begin
                failures++;
                $display("FAIL single_addr: got %0d expected %0d", wr_log[0].addr, exp_q[0]);
            end
            checks++;
            if (wr_log[0].cyc - acc_q[0].cyc !== 2) begin
                failures++;
                $display("FAIL single_latency: got %0d expected 2", wr_log[0].cyc - acc_q[0].cyc);
            end
        end
        finish_stream("single");
    endtask

    task automatic test_clipping();
        int xs[5] = '{-1, 64, 5, 0, 63};
        int ys[5] = '{0, 5, 64, -7, 63};
        ready_mode = 1;
        apply_reset();
        for (int i = 0; i < 5; i++) send(xs[i], ys[i]);
        finish_stream("clip");
        run_model();
        checks++;
        if (wr_log.size() !== exp_q.size() || (wr_log.size() == 1 && wr_log[0].addr !== exp_q[0])) begin
            failures++;
            $display("FAIL clip_writes: got n=%0d expected n=%0d", wr_log.size(), exp_q.size());
        end
        checks++;
        if (int'(_clip_cnt) !== exp_clip) begin
            failures++;
            $display("FAIL clip_cnt: got %0d expected %0d", _clip_cnt, exp_clip);
        end
    endtask

    task automatic test_backpressure();
        int px[10], py[10];
        int ready_seen = 0;
        for (int i = 0; i < 10; i++) begin
            do begin
                px[i] = int'($urandom_range(0, FB_W - 1));
                py[i] = int'($urandom_range(0, FB_H - 1));
            end while (i > 0 && px[i] == px[i-1] && py[i] == py[i-1]);
        end
        ready_mode = 0;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) send(px[i], py[i]);
        _in0 = 32'(px[DEPTH]); _in1 = 32'(py[DEPTH]); _in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge _clock);
            if (_in_ready) ready_seen++;
            step(1);
        end
        _in_valid = 1'b0;
        checks++;
        if (ready_seen !== 0 || acc_q.size() !== DEPTH) begin
            failures++;
            $display("FAIL bp_stall: got accepted=%0d ready_cycles=%0d expected accepted=%0d ready_cycles=0",
                     acc_q.size(), ready_seen, DEPTH);
        end
        checks++;
        if (_wr_valid !== 1'b1 || wr_log.size() !== 0) begin
            failures++;
            $display("FAIL bp_pending: got wv=%b writes=%0d expected wv=1 writes=0", _wr_valid, wr_log.size());
        end
        ready_mode = 1;
        for (int i = DEPTH; i < 10; i++) send(px[i], py[i]);
        finish_stream("bp");
        run_model();
        checks++;
        if (wr_log.size() !== exp_q.size() || exp_q.size() !== 10) begin
            failures++;
            $display("FAIL bp_count: got %0d expected %0d", wr_log.size(), exp_q.size());
        end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i].addr !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_order[%0d]: got %0d expected %0d", i, wr_log[i].addr, exp_q[i]);
            end
        end
        checks++;
        if (stab_err !== 0) begin
            failures++;
            $display("FAIL bp_addr_stable: got %0d changes expected 0", stab_err);
        end
    endtask

    task automatic test_dedup();
        ready_mode = 1;
        apply_reset();
        for (int i = 0; i < 8; i++) send(10, 10);
        finish_stream("dedup");
        run_model();
        checks++;
        if (wr_log.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL dedup_count: got %0d expected %0d", wr_log.size(), exp_q.size());
        end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i].addr !== exp_q[i]) begin
                failures++;
                $display("FAIL dedup_addr[%0d]: got %0d expected %0d", i, wr_log[i].addr, exp_q[i]);
            end
        end
        checks++;
        if (int'(_dup_cnt) !== exp_dup) begin
            failures++;
            $display("FAIL dup_cnt: got %0d expected %0d", _dup_cnt, exp_dup);
        end
    endtask

    task automatic test_simultaneous_done();
        int n_wr;
        ready_mode = 1;
        apply_reset();
        _in0 = 32'd1; _in1 = 32'd1; _in_valid = 1'b1; _in_done = 1'b1;
        @(negedge _clock);
        checks++;
        if (_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL simul_ready: got %b expected 1", _in_ready);
        end
        step(1);
        _in_valid = 1'b0;
        finish_stream("simul");
        run_model();
        checks++;
        if (wr_log.size() !== 1 || exp_q.size() !== 1 || wr_log[0].addr !== exp_q[0]) begin
            failures++;
            $display("FAIL simul_write: got n=%0d expected n=%0d addr=65", wr_log.size(), exp_q.size());
        end
        n_wr = wr_log.size();
        for (int i = 0; i < 3; i++) begin
            _in0 = 32'($urandom_range(0, 63)); _in1 = 32'($urandom_range(0, 63)); _in_valid = 1'b1;
            @(negedge _clock);
            checks++;
            if (_in_ready !== 1'b0 || _done !== 1'b1) begin
                failures++;
                $display("FAIL simul_after_done: got rdy=%b done=%b expected rdy=0 done=1", _in_ready, _done);
            end
            step(1);
            _in_valid = 1'b0;
            step(1);
        end
        step(3);
        checks++;
        if (wr_log.size() !== n_wr) begin
            failures++;
            $display("FAIL simul_no_more_writes: got %0d expected %0d", wr_log.size(), n_wr);
        end
    endtask

    task automatic test_random();
        int x, y;
        ready_mode = 2;
        apply_reset();
        x = 0; y = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                x = int'($urandom_range(0, 79)) - 8;
                y = int'($urandom_range(0, 79)) - 8;
            end
            send(x, y);
            if ($urandom_range(0, 4) == 0) step(int'($urandom_range(1, 3)));
        end
        finish_stream("rand");
        run_model();
        checks++;
        if (wr_log.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL rand_count: got %0d expected %0d", wr_log.size(), exp_q.size());
        end
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_log[i].addr !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_addr[%0d]: got %0d expected %0d", i, wr_log[i].addr, exp_q[i]);
            end
        end
        checks++;
        if (int'(_clip_cnt) !== exp_clip || int'(_dup_cnt) !== exp_dup) begin
            failures++;
            $display("FAIL rand_counters: got clip=%0d dup=%0d expected clip=%0d dup=%0d",
                     _clip_cnt, _dup_cnt, exp_clip, exp_dup);
        end
        checks++;
        if (stab_err !== 0) begin
            failures++;
            $display("FAIL rand_addr_stable: got %0d changes expected 0", stab_err);
        end
    endtask

    task automatic test_reset_mid();
        ready_mode = 0;
        apply_reset();
        send(5, 1); send(6, 1); send(70, 2);
        send(7, 1);
        step(2);
        _reset = 1'b1;
        @(negedge _clock);
        checks++;
        if (_wr_valid !== 1'b0 || wr_log.size() !== 0) begin
            failures++;
            $display("FAIL midreset_during: got wv=%b writes=%0d expected wv=0 writes=0", _wr_valid, wr_log.size());
        end
        step(1);
        _reset = 1'b0;
        acc_q.delete(); wr_log.delete(); stab_err = 0;
        @(negedge _clock);
        checks++;
        if (_wr_valid !== 1'b0 || _in_ready !== 1'b1 || _clip_cnt !== 16'd0 ||
            _dup_cnt !== 16'd0 || _done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_after: got wv=%b rdy=%b clip=%0d dup=%0d done=%b expected wv=0 rdy=1 0 0 0",
                     _wr_valid, _in_ready, _clip_cnt, _dup_cnt, _done);
        end
        ready_mode = 1;
        step(8);
        checks++;
        if (wr_log.size() !== 0) begin
            failures++;
            $display("FAIL midreset_stale: got %0d writes expected 0", wr_log.size());
        end
        send(7, 7);
        step(4);
        run_model();
        checks++;
        if (wr_log.size() !== 1 || exp_q.size() !== 1 || wr_log[0].addr !== exp_q[0]) begin
            failures++;
            $display("FAIL midreset_resume: got n=%0d expected n=%0d", wr_log.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_point();
        test_clipping();
        test_backpressure();
        test_dedup();
        test_simultaneous_done();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
